// File: rtl/stim_pkg.sv
// Shared types and widths for the stimulus checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stim_pkg;
    localparam int VEC_W = 4;
    localparam int CNT_W = 5;
    localparam int TBL_W = 1 << VEC_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;
endpackage

// File: rtl/stim_checker_if.sv
// Bundle between the checker and its environment: run control, vectors, results.
// Latency: n/a (wires only).
// Backpressure: none; start is level-sampled by the checker.
interface stim_checker_if;
    import stim_pkg::*;

    logic             start;
    logic             y;
    logic [TBL_W-1:0] exp_table;
    logic             a;
    logic             b;
    logic             c;
    logic             d;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [VEC_W-1:0] first_err;

    // Checker side: drives vectors and results.
    modport master (
        input  start, y, exp_table,
        output a, b, c, d, busy, done, pass, err_count, first_err
    );

    // Environment side: requests runs, returns the unit's response.
    modport slave (
        output start, y, exp_table,
        input  a, b, c, d, busy, done, pass, err_count, first_err
    );
endinterface

// File: rtl/settle_timer.sv
// Load/count-down timer with a zero flag, used to time the settle window.
// Latency: load and decrement take effect on the next rising edge.
// Backpressure: none; decrement stops at zero.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over decrement; never underflows.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/stim_checker.sv
// Walks NUM_VEC input vectors through a combinational unit and compares y to a table.
// Latency: SETTLE_CYCLES+2 cycles per vector (DRIVE, SETTLE x N, SAMPLE).
// Backpressure: start is ignored while busy; DONE holds results until next start.
module stim_checker
    import stim_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int NUM_VEC       = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    stim_checker_if.master bus
);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VEC - 1);
    // Timer counts load..0 inclusive, so load one less than the window length.
    localparam logic [VEC_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES == 0) ? '0 : VEC_W'(SETTLE_CYCLES - 1);

    state_e           state_q;
    state_e           state_d;
    // idx only changes on entry to DRIVE, so it doubles as the {a,b,c,d} register.
    logic [VEC_W-1:0] idx_q;
    logic [VEC_W-1:0] idx_d;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] err_d;
    logic [VEC_W-1:0] first_q;
    logic [VEC_W-1:0] first_d;
    logic             tmr_load;
    logic             tmr_dec;
    logic             tmr_zero;

    settle_timer #(.W(VEC_W)) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state, counter updates and timer control.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        first_d  = first_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    err_d   = '0;
                    first_d = '0;
                end
            end
            ST_DRIVE: begin
                if (SETTLE_CYCLES == 0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    state_d  = ST_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_SAMPLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (bus.y != bus.exp_table[idx_q]) begin
                    err_d = err_q + CNT_W'(1);
                    if (err_q == '0) begin
                        first_d = idx_q;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + VEC_W'(1);
                    state_d = ST_DRIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Vector index and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign {bus.a, bus.b, bus.c, bus.d} = idx_q;
    assign bus.busy      = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                           (state_q == ST_SAMPLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (err_q == '0);
    assign bus.err_count = err_q;
    assign bus.first_err = first_q;
endmodule
